rbm_visible_layer: RTL

- Downward (reconstruction) pass of the RBM: takes a binary hidden vector h and produces a sampled visible vector v'.
- For each visible unit i: v'[i] = sample(sigmoid(vbias[i] + sum over j of W[i][j]·h[j])).
- Sits after the hidden sampling layer in the Gibbs loop. Reuses the same weight file (visible × hidden layout), read row-wise.
- Serial MAC datapath: one hidden term per cycle, with a valid/ready handshake on both sides.

---
 rtl/rbm_visible_layer_pkg.sv | 24 ++
 rtl/RandomGenerator.sv | 21 ++
 rtl/rbm_visible_layer_sat_mac.sv | 39 +++
 rtl/sigmoid.sv | 15 +
 rtl/rbm_visible_layer.sv | 136 +++++++++++++
 5 files changed

// File: rtl/rbm_visible_layer_pkg.sv
// Shared definitions for the RBM layers: default widths, saturation constants,
// FSM/MAC control encodings, bus packing macros and data-file path defaults.
`ifndef RBM_VISIBLE_LAYER_PKG_SV
`define RBM_VISIBLE_LAYER_PKG_SV

`define PORT_1D(name, n, w) logic [(n)*(w)-1:0] name
`define GET_1D(bus, idx, w) bus[(idx)*(w) +: (w)]

package rbm_visible_layer_pkg;
  localparam int unsigned BITLENGTH         = 12;
  localparam int unsigned SIGMOID_BITLENGTH = 8;
  localparam logic [BITLENGTH-1:0] INF      = 12'b0111_1111_1111;
  localparam logic [BITLENGTH-1:0] NEG_INF  = 12'b1000_0000_0001;
  localparam logic [SIGMOID_BITLENGTH-1:0] SEED_DEFAULT = 8'h5A;

  localparam string WEIGHT_PATH = "../build/data/Hweight15x5.txt";
  localparam string VBIAS_PATH  = "../build/data/Vbias1x15.txt";
  localparam string SEED_PATH   = "../build/data/seed1x10.txt";

  typedef enum logic [1:0] {IDLE, ACCUM, SAMPLE, DONE} state_e;
  typedef enum logic [1:0] {MAC_HOLD, MAC_LOAD, MAC_ADD} mac_op_e;
endpackage

`endif

// File: rtl/RandomGenerator.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4); rand_reset loads the seed.
// Deliberately not tied to the block reset.
module RandomGenerator #(
  parameter int unsigned width = 8,
  parameter logic [width-1:0] seed = 8'h5A
) (
  input  logic             clock,
  input  logic             rand_reset,
  output logic [width-1:0] rand_num
);
  logic [width-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[width-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (rand_reset) lfsr_d = seed;
  end

  always_ff @(posedge clock) lfsr_q <= lfsr_d;

  assign rand_num = lfsr_q;
endmodule

// File: rtl/rbm_visible_layer_sat_mac.sv
// Saturating accumulator shared by the serialized RBM layers: load a bias,
// add one term with clamping to +/-Inf, or hold.
module sat_mac import rbm_visible_layer_pkg::*; #(
  parameter int unsigned bitlength = BITLENGTH,
  parameter logic [bitlength-1:0] Inf = {1'b0, {(bitlength-1){1'b1}}}
) (
  input  logic                 clock,
  input  logic                 reset,
  input  mac_op_e              op,
  input  logic [bitlength-1:0] operand,
  output logic [bitlength-1:0] acc
);
  localparam logic signed [bitlength:0] POS = {1'b0, Inf};
  localparam logic signed [bitlength:0] NEG = -POS;

  logic [bitlength-1:0] acc_q, acc_d;
  logic signed [bitlength:0] sum;

  always_comb begin
    sum   = $signed({acc_q[bitlength-1], acc_q}) + $signed({operand[bitlength-1], operand});
    acc_d = acc_q;
    unique case (op)
      MAC_LOAD: acc_d = operand;
      MAC_ADD: begin
        if (sum > POS)      acc_d = POS[bitlength-1:0];
        else if (sum < NEG) acc_d = NEG[bitlength-1:0];
        else                acc_d = sum[bitlength-1:0];
      end
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/sigmoid.sv
// Piecewise-linear sigmoid: 2^(sw-1) + x/2^(bl-sw), which maps the signed
// accumulator range monotonically onto the full unsigned output range.
module sigmoid #(
  parameter int unsigned bitlength         = 12,
  parameter int unsigned sigmoid_bitlength = 8
) (
  input  logic [bitlength-1:0]         x,
  output logic [sigmoid_bitlength-1:0] y
);
  logic unused_lsbs;

  // Adding the midpoint to the arithmetic shift is just an MSB inversion.
  assign y = {~x[bitlength-1], x[bitlength-2 -: sigmoid_bitlength-1]};
  assign unused_lsbs = ^x[bitlength-sigmoid_bitlength-1:0];
endmodule

// File: rtl/rbm_visible_layer.sv
// RBM downward pass: serial MAC over the hidden vector per visible unit, then
// sigmoid + stochastic sample. Define RBM_MEANFIELD_EN to output sigmoid values instead.
module rbm_visible_layer import rbm_visible_layer_pkg::*; #(
  parameter int unsigned bitlength         = BITLENGTH,
  parameter int unsigned sigmoid_bitlength = SIGMOID_BITLENGTH,
  parameter int unsigned visible_dim       = 15,
  parameter int unsigned hidden_dim        = 5,
  parameter logic [bitlength-1:0] Inf      = {1'b0, {(bitlength-1){1'b1}}},
  parameter logic [visible_dim*hidden_dim*bitlength-1:0] weight_init = '0,
  parameter logic [visible_dim*bitlength-1:0]            vbias_init  = '0,
  parameter logic [sigmoid_bitlength-1:0]                seed        = SEED_DEFAULT
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            rand_reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [hidden_dim*bitlength-1:0] HiddenData,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [visible_dim*bitlength-1:0] VisibleData
);
  localparam int unsigned VI_W = (visible_dim > 1) ? $clog2(visible_dim) : 1;
  localparam int unsigned HJ_W = (hidden_dim > 1) ? $clog2(hidden_dim) : 1;
  localparam logic [VI_W-1:0] VI_LAST = VI_W'(visible_dim - 1);
  localparam logic [HJ_W-1:0] HJ_LAST = HJ_W'(hidden_dim - 1);

  state_e state_q, state_d;
  logic [hidden_dim-1:0]            hreg_q, hreg_d, active;
  logic [VI_W-1:0]                  vi_q, vi_d;
  logic [HJ_W-1:0]                  hj_q, hj_d;
  logic [visible_dim*bitlength-1:0] vis_q, vis_d;
  mac_op_e                          mac_op;
  logic [bitlength-1:0]             mac_operand, acc;
  logic [sigmoid_bitlength-1:0]     sig_val;
  logic [bitlength-1:0]             field_val;

  sat_mac #(.bitlength(bitlength), .Inf(Inf)) u_mac (
    .clock(clock), .reset(reset), .op(mac_op), .operand(mac_operand), .acc(acc)
  );

  sigmoid #(.bitlength(bitlength), .sigmoid_bitlength(sigmoid_bitlength)) u_sigmoid (
    .x(acc), .y(sig_val)
  );

`ifdef RBM_MEANFIELD_EN
  logic unused_rand_reset;
  assign unused_rand_reset = rand_reset;
  assign field_val = bitlength'(sig_val);
`else
  logic [sigmoid_bitlength-1:0] rand_num;
  RandomGenerator #(.width(sigmoid_bitlength), .seed(seed)) u_rng (
    .clock(clock), .rand_reset(rand_reset), .rand_num(rand_num)
  );
  assign field_val = bitlength'(sig_val > rand_num);
`endif

  // Only the zero/nonzero status of each hidden field matters, so keep one bit per field.
  always_comb begin
    active = '0;
    for (int unsigned j = 0; j < hidden_dim; j++)
      active[j] = |`GET_1D(HiddenData, j, bitlength);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = ACCUM;
      ACCUM:   if (hj_q == HJ_LAST) state_d = SAMPLE;
      SAMPLE:  state_d = (vi_q == VI_LAST) ? DONE : ACCUM;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    hreg_d      = hreg_q;
    vi_d        = vi_q;
    hj_d        = hj_q;
    vis_d       = vis_q;
    mac_op      = MAC_HOLD;
    mac_operand = '0;
    unique case (state_q)
      IDLE: if (in_valid) begin
        hreg_d      = active;
        vi_d        = '0;
        hj_d        = '0;
        mac_op      = MAC_LOAD;
        mac_operand = `GET_1D(vbias_init, 0, bitlength);
      end
      ACCUM: begin
        if (hreg_q[hj_q]) begin
          mac_op      = MAC_ADD;
          mac_operand = `GET_1D(weight_init, int'(vi_q) * hidden_dim + int'(hj_q), bitlength);
        end
        hj_d = hj_q + 1'b1;
      end
      SAMPLE: begin
        `GET_1D(vis_d, int'(vi_q), bitlength) = field_val;
        if (vi_q != VI_LAST) begin
          vi_d        = vi_q + 1'b1;
          hj_d        = '0;
          mac_op      = MAC_LOAD;
          mac_operand = `GET_1D(vbias_init, int'(vi_q) + 1, bitlength);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hreg_q <= '0;
      vi_q   <= '0;
      hj_q   <= '0;
      vis_q  <= '0;
    end else begin
      hreg_q <= hreg_d;
      vi_q   <= vi_d;
      hj_q   <= hj_d;
      vis_q  <= vis_d;
    end
  end

  assign VisibleData = vis_q;
endmodule
